// File: rtl/jm_pkg.sv
// Shared definitions for the job-manager kernel adapter: FSM state encoding,
// the timeout return code and default descriptor layout.
package jm_pkg;

    // ST_HALT is only reachable when JM_KERNEL_WATCHDOG_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } jm_state_e;

    // All-ones return code reported on watchdog timeout. It is wide enough
    // for any practical RC_WIDTH; users take the low RC_WIDTH bits.
    localparam logic [63:0] RC_TIMEOUT = '1;

    // The job-descriptor header occupies the low 64 bits of jd_payload.
    localparam int DEF_ARG_OFFSET = 64;

endpackage

// File: rtl/jm_sat_counter.sv
// Saturating up-counter with synchronous clear, count enable and an
// equality compare output. Used for the kernel run-time count, and its
// compare output feeds the optional watchdog.
module jm_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             cmp_eq
);

    // Count up while enabled, hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign cmp_eq = (count == cmp_val);

endmodule

// File: rtl/jm_kernel_adapter.sv
// Adapter between one job-manager kernel slot and an HLS ap_ctrl_hs kernel.
// Latches the kernel arguments from the job descriptor, runs the ap_start /
// ap_ready / ap_done handshake, reports completion with engine_done and
// return_code, and measures kernel run time in cycle_count.
//
// Optional watchdog: define JM_KERNEL_WATCHDOG_EN to time out a kernel that
// runs for WDOG_LIMIT cycles; the slot then reports RC_TIMEOUT and parks in
// HALT until the kernel shows ap_done or ap_idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no job; accepts engine_start
// ST_START | ap_start asserted, waiting for ap_ready
// ST_RUN   | arguments taken, waiting for ap_done
// ST_HALT  | timed out, done already reported; waiting for kernel to settle
module jm_kernel_adapter
    import jm_pkg::*;
#(
    parameter int          HOST_DWIDTH = 1024,
    parameter int          ARG_OFFSET  = DEF_ARG_OFFSET,
    parameter int          ARG_WIDTH   = 512,
    parameter int          RC_WIDTH    = 8,
    parameter int          CYC_WIDTH   = 32,
    parameter int unsigned WDOG_LIMIT  = 2**24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   engine_start,
    input  logic [HOST_DWIDTH-1:0] jd_payload,
    output logic                   engine_done,
    output logic [RC_WIDTH-1:0]    return_code,
    output logic                   busy,
    output logic                   ap_start,
    input  logic                   ap_ready,
    input  logic                   ap_done,
    input  logic                   ap_idle,
    input  logic [RC_WIDTH-1:0]    ap_return,
    output logic [ARG_WIDTH-1:0]   kernel_args,
    output logic [CYC_WIDTH-1:0]   cycle_count
);

    localparam logic [CYC_WIDTH-1:0] WDOG_CMP = CYC_WIDTH'(WDOG_LIMIT);
    localparam logic [RC_WIDTH-1:0]  RC_TO    = RC_TIMEOUT[RC_WIDTH-1:0];

    jm_state_e               state;
    jm_state_e               state_nxt;
    logic                    done_nxt;
    logic [RC_WIDTH-1:0]     rc_nxt;
    logic [ARG_WIDTH-1:0]    args_nxt;
    logic                    cnt_clr;
    logic                    cnt_en;
    logic                    cnt_eq;
    logic                    wdog_hit;

    jm_sat_counter #(
        .WIDTH (CYC_WIDTH)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cmp_val (WDOG_CMP),
        .count   (cycle_count),
        .cmp_eq  (cnt_eq)
    );

`ifdef JM_KERNEL_WATCHDOG_EN
    assign wdog_hit = cnt_eq;
`else
    assign wdog_hit = 1'b0;
`endif

    // Decoded from the state register so both drop the moment reset asserts.
    assign ap_start = (state == ST_START);
    assign busy     = (state != ST_IDLE);

    // Descriptor header bits and unused handshake inputs are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{jd_payload, ap_idle, cnt_eq};

    // State register plus the registered completion outputs and argument latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            engine_done <= 1'b0;
            return_code <= '0;
            kernel_args <= '0;
        end else begin
            state       <= state_nxt;
            engine_done <= done_nxt;
            return_code <= rc_nxt;
            kernel_args <= args_nxt;
        end
    end

    // Next-state and next-output decode. ap_done wins over a same-cycle
    // timeout, and a done sampled in START completes without visiting RUN.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        rc_nxt    = return_code;
        args_nxt  = kernel_args;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (engine_start) begin
                    state_nxt = ST_START;
                    args_nxt  = jd_payload[ARG_OFFSET +: ARG_WIDTH];
                    cnt_clr   = 1'b1;
                end
            end
            ST_START, ST_RUN: begin
                cnt_en = 1'b1;
                if (ap_done) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    rc_nxt    = ap_return;
                end else if (wdog_hit) begin
                    state_nxt = ST_HALT;
                    done_nxt  = 1'b1;
                    rc_nxt    = RC_TO;
                    cnt_en    = 1'b0;
                end else if ((state == ST_START) && ap_ready) begin
                    state_nxt = ST_RUN;
                end
            end
`ifdef JM_KERNEL_WATCHDOG_EN
            ST_HALT: begin
                if (ap_done || ap_idle) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jm_kernel_adapter.sv
// Directed self-checking bench for jm_kernel_adapter.
// Inputs are driven and outputs observed 1 time unit after each rising edge.
module tb_jm_kernel_adapter;

    localparam int HOST_DWIDTH = 1024;
    localparam int ARG_OFFSET  = 64;
    localparam int ARG_WIDTH   = 512;
    localparam int RC_WIDTH    = 8;
    localparam int CYC_WIDTH   = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   engine_start;
    logic [HOST_DWIDTH-1:0] jd_payload;
    logic                   engine_done;
    logic [RC_WIDTH-1:0]    return_code;
    logic                   busy;
    logic                   ap_start;
    logic                   ap_ready;
    logic                   ap_done;
    logic                   ap_idle;
    logic [RC_WIDTH-1:0]    ap_return;
    logic [ARG_WIDTH-1:0]   kernel_args;
    logic [CYC_WIDTH-1:0]   cycle_count;

    int n_checks = 0;
    int n_err    = 0;

    logic [ARG_WIDTH-1:0] arg_a;
    logic [ARG_WIDTH-1:0] arg_b;
    logic [ARG_WIDTH-1:0] arg_c;

    jm_kernel_adapter #(
        .HOST_DWIDTH (HOST_DWIDTH),
        .ARG_OFFSET  (ARG_OFFSET),
        .ARG_WIDTH   (ARG_WIDTH),
        .RC_WIDTH    (RC_WIDTH),
        .CYC_WIDTH   (CYC_WIDTH),
        .WDOG_LIMIT  (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .engine_start (engine_start),
        .jd_payload   (jd_payload),
        .engine_done  (engine_done),
        .return_code  (return_code),
        .busy         (busy),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .ap_return    (ap_return),
        .kernel_args  (kernel_args),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [ARG_WIDTH-1:0] obs,
                         input logic [ARG_WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload with arguments in place and recognisable junk in the header and upper bits.
    function automatic logic [HOST_DWIDTH-1:0] mk_payload(input logic [ARG_WIDTH-1:0] args);
        logic [HOST_DWIDTH-1:0] p;
        p = {HOST_DWIDTH/32{32'hC0FF_EE11}};
        p[ARG_OFFSET +: ARG_WIDTH] = args;
        return p;
    endfunction

    initial begin
        arg_a = {16{32'hA5A5_0001}};
        arg_b = {16{32'h1234_B00B}};
        arg_c = {16{32'hCCCC_3333}};

        rst_n        = 1'b0;
        engine_start = 1'b0;
        jd_payload   = '0;
        ap_ready     = 1'b0;
        ap_done      = 1'b0;
        ap_idle      = 1'b0;
        ap_return    = '0;
        #12;
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_ap_start", ap_start, 0);
        check("rst_busy", busy, 0);
        check("rst_engine_done", engine_done, 0);
        check("rst_return_code", return_code, 0);
        check("rst_kernel_args", kernel_args, 0);
        check("rst_cycle_count", cycle_count, 0);

        // Single job: start at t, ready at t+3, done at t+10
        engine_start = 1'b1;
        jd_payload   = mk_payload(arg_a);
        tick();                                   // t+1
        engine_start = 1'b0;
        jd_payload   = '0;
        check("j1_ap_start_t1", ap_start, 1);
        check("j1_busy_t1", busy, 1);
        check("j1_kernel_args", kernel_args, arg_a);
        tick();                                   // t+2
        check("j1_ap_start_t2", ap_start, 1);
        tick();                                   // t+3
        ap_ready = 1'b1;
        check("j1_ap_start_t3", ap_start, 1);
        tick();                                   // t+4
        ap_ready = 1'b0;
        check("j1_ap_start_t4", ap_start, 0);
        repeat (6) tick();                        // t+10
        check("j1_no_early_done", engine_done, 0);
        ap_done   = 1'b1;
        ap_return = 8'h5A;
        tick();                                   // t+11
        ap_done   = 1'b0;
        ap_return = 8'h00;
        check("j1_engine_done", engine_done, 1);
        check("j1_return_code", return_code, 8'h5A);
        check("j1_cycle_count", cycle_count, 10);
        check("j1_busy_done", busy, 0);
        tick();                                   // t+12
        check("j1_done_one_cycle", engine_done, 0);
        check("j1_rc_held", return_code, 8'h5A);
        check("j1_count_frozen", cycle_count, 10);

        // Spurious ap_done in IDLE
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        tick();
        check("idle_done_ignored", engine_done, 0);
        check("idle_busy", busy, 0);

        // ap_ready and ap_done together in the first START cycle
        engine_start = 1'b1;
        jd_payload   = mk_payload(arg_a);
        tick();                                   // u+1
        engine_start = 1'b0;
        ap_ready     = 1'b1;
        ap_done      = 1'b1;
        ap_return    = 8'h33;
        tick();                                   // u+2
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        ap_return = 8'h00;
        check("rd_engine_done", engine_done, 1);
        check("rd_return_code", return_code, 8'h33);
        check("rd_cycle_count", cycle_count, 1);
        check("rd_busy", busy, 0);
        check("rd_ap_start", ap_start, 0);

        // Back-to-back: new start during the engine_done cycle
        engine_start = 1'b1;
        jd_payload   = mk_payload(arg_b);
        tick();                                   // u+3
        engine_start = 1'b0;
        jd_payload   = '0;
        check("b2b_done_single", engine_done, 0);
        check("b2b_ap_start", ap_start, 1);
        check("b2b_kernel_args", kernel_args, arg_b);
        check("b2b_cycle_count", cycle_count, 0);
        check("b2b_busy", busy, 1);
        ap_ready = 1'b1;
        tick();                                   // u+4
        ap_ready = 1'b0;

        // Start while busy with payload C must be ignored
        engine_start = 1'b1;
        jd_payload   = mk_payload(arg_c);
        tick();                                   // u+5
        engine_start = 1'b0;
        jd_payload   = '0;
        check("busy_args_kept", kernel_args, arg_b);
        check("busy_ap_start", ap_start, 0);
        check("busy_busy", busy, 1);
        tick();                                   // u+6
        ap_done   = 1'b1;
        ap_return = 8'h77;
        tick();                                   // u+7
        ap_done   = 1'b0;
        ap_return = 8'h00;
        check("busy_engine_done", engine_done, 1);
        check("busy_return_code", return_code, 8'h77);
        check("busy_cycle_count", cycle_count, 4);
        tick();                                   // u+8
        check("busy_single_done", engine_done, 0);
        check("busy_no_restart", ap_start, 0);
        check("busy_idle", busy, 0);

        // Reset asserted mid-RUN, between clock edges
        engine_start = 1'b1;
        jd_payload   = mk_payload(arg_a);
        tick();
        engine_start = 1'b0;
        ap_ready     = 1'b1;
        tick();
        ap_ready = 1'b0;
        tick();
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ap_start", ap_start, 0);
        check("arst_busy", busy, 0);
        check("arst_engine_done", engine_done, 0);
        check("arst_kernel_args", kernel_args, 0);
        check("arst_cycle_count", cycle_count, 0);
        #3;
        rst_n = 1'b1;
        tick();
        ap_done   = 1'b1;
        ap_return = 8'h11;
        tick();
        ap_done   = 1'b0;
        ap_return = 8'h00;
        check("post_rst_no_done", engine_done, 0);
        check("post_rst_ap_start", ap_start, 0);
        check("post_rst_rc", return_code, 0);

`ifndef JM_KERNEL_WATCHDOG_EN
        // Run-time counter saturates instead of wrapping
        engine_start = 1'b1;
        jd_payload   = mk_payload(arg_c);
        tick();
        engine_start = 1'b0;
        ap_ready     = 1'b1;
        tick();
        ap_ready = 1'b0;
        repeat (300) tick();
        check("sat_cycle_count", cycle_count, 255);
        check("sat_busy", busy, 1);
        ap_done   = 1'b1;
        ap_return = 8'h42;
        tick();
        ap_done   = 1'b0;
        ap_return = 8'h00;
        check("sat_engine_done", engine_done, 1);
        check("sat_return_code", return_code, 8'h42);
        check("sat_count_held", cycle_count, 255);
`else
        // Watchdog: ap_done never arrives, limit 100 cycles
        engine_start = 1'b1;
        jd_payload   = mk_payload(arg_c);
        tick();                                   // t+1, ap_start rises
        engine_start = 1'b0;
        jd_payload   = '0;
        repeat (100) tick();                      // t+101
        check("wd_no_early_done", engine_done, 0);
        tick();                                   // t+102
        check("wd_engine_done", engine_done, 1);
        check("wd_return_code", return_code, 8'hFF);
        check("wd_busy", busy, 1);
        check("wd_ap_start", ap_start, 0);
        engine_start = 1'b1;
        jd_payload   = mk_payload(arg_a);
        tick();                                   // t+103
        engine_start = 1'b0;
        jd_payload   = '0;
        check("wd_halt_single_done", engine_done, 0);
        check("wd_halt_rejects", kernel_args, arg_c);
        check("wd_halt_busy", busy, 1);
        check("wd_halt_no_start", ap_start, 0);
        ap_idle = 1'b1;
        tick();                                   // t+104
        ap_idle = 1'b0;
        check("wd_idle_busy", busy, 0);
        check("wd_idle_no_done", engine_done, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
